dp3_ctrl: RTL and testbench

- Multi-cycle FSM controller that sequences the dp3 accumulator datapath as a tiny stored-program processor.
- Fetches 8-bit instructions from an asynchronous-read program/data memory, decodes them, and drives dp3 controls (Aload, Sub, Asel) plus memory address and write enable.
- Uses dp3 status flags (Apos, Aeq0) for conditional jumps and the user "enter" button for INPUT.

---
 rtl/dp3_pkg.sv | 35 +++
 rtl/dp3_ctrl.sv | 128 ++++++++++++
 tb/tb_dp3_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp3_pkg.sv
// dp3_pkg: shared encodings for the dp3 controller (opcodes, FSM states,
// accumulator source select values and instruction field layout).
package dp3_pkg;

  localparam int DP3_OP_W   = 3;
  localparam int DP3_ADDR_W = 5;
  localparam int INSTR_W    = DP3_OP_W + DP3_ADDR_W;
  localparam int OP_MSB     = INSTR_W - 1;
  localparam int OP_LSB     = DP3_ADDR_W;
  localparam int ADDR_MSB   = DP3_ADDR_W - 1;
  localparam int ADDR_LSB   = 0;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_PROD = 2'd0;
  localparam logic [1:0] ASEL_IN   = 2'd1;
  localparam logic [1:0] ASEL_MEM  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXEC       = 3'd2,
    S_INPUT_WAIT = 3'd3,
    S_INPUT_REL  = 3'd4,
    S_HALT       = 3'd5
  } state_t;

endpackage

// File: rtl/dp3_ctrl.sv
// dp3_ctrl: multi-cycle fetch/decode/execute controller for the dp3 datapath.
// Optional macro DP3_CTRL_SINGLE_STEP_EN adds a step input gating each FETCH.
`default_nettype none
module dp3_ctrl
  import dp3_pkg::*;
#(
  parameter int ADDR_W   = DP3_ADDR_W,
  parameter int OP_W     = DP3_OP_W,
  parameter int RESET_PC = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enter,
`ifdef DP3_CTRL_SINGLE_STEP_EN
  input  logic                   step,
`endif
  input  logic [OP_W+ADDR_W-1:0] instr,
  input  logic                   Apos,
  input  logic                   Aeq0,
  output logic                   Aload,
  output logic                   Sub,
  output logic [1:0]             Asel,
  output logic [ADDR_W-1:0]      memAddr,
  output logic                   memWe,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halt
);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [OP_W+ADDR_W-1:0]   ir_q, ir_d;
  logic [OP_W-1:0]          ir_op;
  logic [ADDR_W-1:0]        ir_addr;
  logic                     fetch_go;

  assign ir_op   = ir_q[OP_W+ADDR_W-1 -: OP_W];
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign pc      = pc_q;

`ifdef DP3_CTRL_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = ASEL_PROD;
    memAddr = ir_addr;
    memWe   = 1'b0;
    halt    = 1'b0;

    case (state_q)
      S_FETCH: begin
        memAddr = pc_q;
        if (fetch_go) begin
          ir_d    = instr;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_op)
          OP_INPUT: state_d = S_INPUT_WAIT;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_op)
          OP_LOAD: begin
            Aload = 1'b1;
            Asel  = ASEL_MEM;
          end
          OP_ADD: Aload = 1'b1;
          OP_SUB: begin
            Aload = 1'b1;
            Sub   = 1'b1;
          end
          OP_STORE: memWe = 1'b1;
          OP_JZ:    if (Aeq0) pc_d = ir_addr;
          OP_JPOS:  if (Apos) pc_d = ir_addr;
          default: ;
        endcase
      end
      S_INPUT_WAIT: begin
        if (enter) begin
          Aload   = 1'b1;
          Asel    = ASEL_IN;
          state_d = S_INPUT_REL;
        end
      end
      S_INPUT_REL: begin
        if (!enter) state_d = S_FETCH;
      end
      S_HALT: halt = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Reset can land mid-instruction; keep the datapath and memory untouched.
    if (reset) begin
      Aload = 1'b0;
      Sub   = 1'b0;
      Asel  = ASEL_PROD;
      memWe = 1'b0;
      halt  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp3_ctrl.sv
// tb_dp3_ctrl: instruction-level reference model expands each instruction into
// its expected per-cycle outputs; a dp3/memory environment closes the loop.
`timescale 1ns/1ps
module tb_dp3_ctrl;
  import dp3_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic [7:0] instr;
  logic       Apos, Aeq0, Aload, Sub, memWe, halt;
  logic [1:0] Asel;
  logic [4:0] memAddr, pc;
`ifdef DP3_CTRL_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  dp3_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .enter   (enter),
`ifdef DP3_CTRL_SINGLE_STEP_EN
    .step    (step),
`endif
    .instr   (instr),
    .Apos    (Apos),
    .Aeq0    (Aeq0),
    .Aload   (Aload),
    .Sub     (Sub),
    .Asel    (Asel),
    .memAddr (memAddr),
    .memWe   (memWe),
    .pc      (pc),
    .halt    (halt)
  );

  always #5 clock = ~clock;

  // dp3 accumulator + memory environment driven by the DUT controls
  logic [7:0] env_mem [32];
  logic [7:0] init_mem[32];
  logic [7:0] env_a = 8'd0;
  logic [7:0] preset_a = 8'd0;
  logic [7:0] in_val = 8'd0;
  logic       preset = 1'b0;

  assign instr = env_mem[memAddr];
  assign Aeq0  = (env_a == 8'd0);
  assign Apos  = !env_a[7] && (env_a != 8'd0);

  always @(posedge clock) begin
    if (preset) begin
      env_a <= preset_a;
      for (int i = 0; i < 32; i++) env_mem[i] <= init_mem[i];
    end else begin
      if (Aload) begin
        case (Asel)
          2'd0: env_a <= Sub ? env_a - instr : env_a + instr;
          2'd1: env_a <= in_val;
          2'd2: env_a <= instr;
          default: ;
        endcase
      end
      if (memWe) env_mem[memAddr] <= env_a;
    end
  end

  typedef struct packed {
    logic       en;
    logic [7:0] val;
    logic       aload;
    logic       sub;
    logic [1:0] asel;
    logic [4:0] addr;
    logic       we;
    logic [4:0] pc;
    logic       halt;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic check_en = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   aload_cnt = 0;
  int   we_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
    tests++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s: got %0d, need %0d", nm, got, need);
    end
  endtask

  task automatic push(input logic en, input logic [7:0] v, input logic al, input logic sb,
                      input logic [1:0] as, input logic [4:0] ad, input logic we,
                      input logic [4:0] p, input logic h);
    exp_t e;
    e.en = en; e.val = v; e.aload = al; e.sub = sb; e.asel = as;
    e.addr = ad; e.we = we; e.pc = p; e.halt = h;
    q.push_back(e);
  endtask

  // Executes the program one instruction at a time, emitting the cycles each takes.
  task automatic gen(input int maxc, input int nhalt, input bit rnd,
                     input int w0, input int h0, input logic [7:0] v0);
    logic [7:0] mm[32];
    logic [7:0] a, ir, v;
    logic [4:0] p, ad;
    logic [2:0] op;
    int w, h;
    mm = init_mem;
    a  = preset_a;
    p  = 5'd0;
    q.delete();
    while (q.size() < maxc) begin
      ir = mm[p];
      op = ir[7:5];
      ad = ir[4:0];
      push(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, p, 1'b0, p, 1'b0);
      p = p + 5'd1;
      if (op == OP_INPUT) begin
        if (rnd) begin
          w = $urandom_range(0, 3); h = $urandom_range(1, 3); v = 8'($urandom);
        end else begin
          w = w0; h = h0; v = v0;
        end
        push(w == 0, v, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
        for (int i = 0; i < w; i++) push(1'b0, v, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
        push(1'b1, v, 1'b1, 1'b0, 2'd1, ad, 1'b0, p, 1'b0);
        a = v;
        for (int i = 1; i < h; i++) push(1'b1, v, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
        push(1'b0, v, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
      end else if (op == OP_HALT) begin
        push(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
        for (int i = 0; i < nhalt; i++) push(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b1);
        break;
      end else begin
        push(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
        case (op)
          OP_LOAD: begin push(1'b0, 8'd0, 1'b1, 1'b0, 2'd2, ad, 1'b0, p, 1'b0); a = mm[ad]; end
          OP_ADD:  begin push(1'b0, 8'd0, 1'b1, 1'b0, 2'd0, ad, 1'b0, p, 1'b0); a = a + mm[ad]; end
          OP_SUB:  begin push(1'b0, 8'd0, 1'b1, 1'b1, 2'd0, ad, 1'b0, p, 1'b0); a = a - mm[ad]; end
          OP_STORE: begin push(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, ad, 1'b1, p, 1'b0); mm[ad] = a; end
          OP_JZ: begin
            push(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
            if (a == 8'd0) p = ad;
          end
          default: begin
            push(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, ad, 1'b0, p, 1'b0);
            if ($signed(a) > 0) p = ad;
          end
        endcase
      end
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      tests++;
      if ({Aload, Sub, Asel, memAddr, memWe, pc, halt} !==
          {cur.aload, cur.sub, cur.asel, cur.addr, cur.we, cur.pc, cur.halt}) begin
        fails++;
        $display("FAIL cycle %0d: got aload=%b sub=%b asel=%0d addr=%0d we=%b pc=%0d halt=%b, need aload=%b sub=%b asel=%0d addr=%0d we=%b pc=%0d halt=%b",
                 cyc, Aload, Sub, Asel, memAddr, memWe, pc, halt,
                 cur.aload, cur.sub, cur.asel, cur.addr, cur.we, cur.pc, cur.halt);
      end
      if (Aload) aload_cnt++;
      if (memWe && we_cyc < 0) we_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; preset = 1'b1; check_en = 1'b0; enter = 1'b0;
    @(negedge clock);
    chk("rst1_ctl", {Aload, memWe, halt}, 0);
    @(posedge clock); #1;
    preset = 1'b0;
    @(negedge clock);
    chk("rst2_ctl", {Aload, memWe, halt}, 0);
    chk("rst2_pc", pc, 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic run_prog(input int maxc, input int nhalt, input bit rnd,
                          input int w0, input int h0, input logic [7:0] v0);
    gen(maxc, nhalt, rnd, w0, h0, v0);
    aload_cnt = 0;
    we_cyc    = -1;
    do_reset();
    for (int i = 0; i < q.size(); i++) begin
      cur = q[i]; enter = cur.en; in_val = cur.val; cyc = i + 1; check_en = 1'b1;
      @(posedge clock); #1;
    end
    check_en = 1'b0;
    enter    = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] b);
    for (int i = 0; i < 32; i++) init_mem[i] = b;
  endtask

  initial begin
    // Straight-line arithmetic and store
    fill_mem(8'hE0);
    init_mem[0] = 8'h14; init_mem[1] = 8'h55; init_mem[2] = 8'h76; init_mem[3] = 8'h37;
    init_mem[4] = 8'hE0;
    init_mem[20] = 8'd10; init_mem[21] = 8'd5; init_mem[22] = 8'd3;
    preset_a = 8'd0;
    run_prog(200, 20, 1'b0, 0, 1, 8'd0);
    chk("arith_model_len", q.size(), 34);
    chk("arith_model_store", {q[11].we, q[11].addr}, {1'b1, 5'd23});
    chk("arith_we_cycle", we_cyc, 12);
    chk("arith_mem23", env_mem[23], 12);
    chk("arith_aloads", aload_cnt, 3);
    chk("arith_halt_pc", pc, 5);
    chk("arith_halt", halt, 1);

    // INPUT handshake: 5 low, 4 high, then low
    fill_mem(8'hE0);
    init_mem[0] = 8'h80;
    run_prog(200, 5, 1'b0, 5, 4, 8'h37);
    chk("input_model_resume", {q[12].addr, q[12].pc}, {5'd1, 5'd1});
    chk("input_aloads", aload_cnt, 1);
    chk("input_a", env_a, 8'h37);
    chk("input_pc", pc, 2);

    // Conditional jumps
    fill_mem(8'hE0);
    init_mem[0] = 8'hAA;
    preset_a = 8'd0;
    run_prog(200, 3, 1'b0, 0, 1, 8'd0);
    chk("jz_taken_pc", pc, 11);
    preset_a = 8'd5;
    run_prog(200, 3, 1'b0, 0, 1, 8'd0);
    chk("jz_not_taken_pc", pc, 2);
    init_mem[0] = 8'hC7;
    run_prog(200, 3, 1'b0, 0, 1, 8'd0);
    chk("jpos_taken_pc", pc, 8);
    init_mem[0] = 8'hDE; init_mem[30] = 8'h1D; init_mem[29] = 8'd0; init_mem[31] = 8'hCA;
    run_prog(200, 3, 1'b0, 0, 1, 8'd0);
    chk("wrap_model_fetch0", {q[9].addr, q[9].pc}, {5'd0, 5'd0});
    chk("wrap_pc", pc, 2);

    // Reset landing in the EXEC cycle of ADD
    fill_mem(8'hE0);
    init_mem[0] = 8'h14; init_mem[1] = 8'h55; init_mem[20] = 8'd10; init_mem[21] = 8'd5;
    preset_a = 8'd0;
    do_reset();
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midop_exec_addr", memAddr, 21);
    chk("midop_aload", Aload, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("midop_pc", pc, 0);
    chk("midop_fetch_addr", memAddr, 0);
    chk("midop_a", env_a, 10);

`ifdef DP3_CTRL_SINGLE_STEP_EN
    step = 1'b0;
    do_reset();
    aload_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("step_hold_pc", pc, 0);
      chk("step_hold_aload", Aload, 0);
      @(posedge clock); #1;
    end
    step = 1'b1;
    @(posedge clock); #1 step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (Aload) aload_cnt++;
      @(posedge clock); #1;
    end
    chk("step_one_aload", aload_cnt, 1);
    chk("step_one_pc", pc, 1);
    chk("step_a", env_a, 10);
    step = 1'b1;
`endif

    // Randomized programs
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 32; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b[7:5] == 3'b111 && $urandom_range(0, 3) != 0) b = b ^ 8'h20;
        init_mem[i] = b;
      end
      preset_a = 8'($urandom);
      run_prog(300, 3, 1'b1, 0, 1, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
